load_store_unit: RTL

- Next-generation data-memory access block for the QingFeng core. It replaces the fixed single-cycle DTCM path with a req/gnt/rvalid bus handshake that tolerates wait states.
- Handles byte-lane alignment, load sign/zero extension and optional split of misaligned accesses into two bus beats.
- Adds a parametrised response timeout and error reporting.
- Sits in EX: takes the EX-stage memory op, stalls the pipeline until completion, and returns extended load data for write-back.

---
 rtl/qf_lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/qf_lsu_pkg.sv
// Shared definitions for the QingFeng load/store unit.
// Holds the funct3 access-type encodings, the FSM state encoding and the
// byte-lane helpers used by the control FSM and by the lane aligner.
package qf_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ1 = 3'd1,
    ST_RSP1 = 3'd2,
    ST_REQ2 = 3'd3,
    ST_RSP2 = 3'd4
  } lsu_state_e;

  // True for the five funct3 codes that describe a real access.
  function automatic logic type_valid(input logic [2:0] t);
    case (t)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // 8-lane mask spanning two consecutive words; lanes 7..4 belong to the
  // second word. Unsigned store variants collapse onto B/H.
  function automatic logic [7:0] calc_be8(input logic [2:0] t, input logic [1:0] off);
    logic [7:0] m;
    case (t)
      LSU_B, LSU_BU: m = 8'h01;
      LSU_H, LSU_HU: m = 8'h03;
      default:       m = 8'h0F;
    endcase
    return m << off;
  endfunction

  // An access is misaligned when it crosses a word boundary.
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    case (t)
      LSU_H, LSU_HU: return (off == 2'd3);
      LSU_W:         return (off != 2'd0);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports: rw_type_i/off_i select size and byte offset; wdata_i is store data,
// beat2_i selects the upper word of the two-word window. be_o/wdata_o are the
// per-beat byte enables and steered write data. beat1_rdata_i (saved first
// beat), rdata_i (current response) and two_beat_i build the load window;
// rdata_o is the shifted and extended load result.
module lsu_align
  import qf_lsu_pkg::*;
(
  input  logic [2:0]  rw_type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic        beat2_i,
  input  logic        two_beat_i,
  input  logic [31:0] beat1_rdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be8_s;
  logic [63:0] wide_wdata_s;
  logic [63:0] window_s;
  logic [31:0] shifted_s;

  always_comb begin
    be8_s        = calc_be8(rw_type_i, off_i);
    wide_wdata_s = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
    if (beat2_i) begin
      be_o    = be8_s[7:4];
      wdata_o = wide_wdata_s[63:32];
    end else begin
      be_o    = be8_s[3:0];
      wdata_o = wide_wdata_s[31:0];
    end
  end

  // The response of a split load is the upper word, the saved beat the lower.
  always_comb begin
    if (two_beat_i) begin
      window_s = {rdata_i, beat1_rdata_i};
    end else begin
      window_s = {32'h0000_0000, rdata_i};
    end
    shifted_s = 32'(window_s >> {off_i, 3'b000});
    case (rw_type_i)
      LSU_B:   rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LSU_H:   rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LSU_BU:  rdata_o = {24'h00_0000, shifted_s[7:0]};
      LSU_HU:  rdata_o = {16'h0000, shifted_s[15:0]};
      default: rdata_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// EX-stage data-memory access unit with a req/gnt/rvalid bus.
// Pipeline side: ex_* describe the memory op; lsu_stall holds the front end,
// lsu_done/lsu_err/lsu_rdata are registered completion outputs.
// Bus side: bus_req/bus_we/bus_addr/bus_be/bus_wdata issue a word beat,
// bus_gnt accepts it, bus_rvalid/bus_rdata/bus_err return the response.
// Misaligned accesses are split into two beats or rejected (MISALIGN_SPLIT);
// every beat is bounded by TIMEOUT_CYCLES (0 = unbounded).
module load_store_unit
  import qf_lsu_pkg::*;
#(
  parameter int MISALIGN_SPLIT = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_rw_type,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] beat1_q, beat1_d;
  logic        is_load_q, two_beat_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q;

  logic        start_s, ex_bad_s, in_req_s, beat2_s, timeout_s;
  logic [3:0]  be_s;
  logic [31:0] lane_wdata_s, load_data_s;

  lsu_align u_align (
    .rw_type_i     (type_q),
    .off_i         (addr_q[1:0]),
    .wdata_i       (wdata_q),
    .beat2_i       (beat2_s),
    .two_beat_i    (two_beat_q),
    .beat1_rdata_i (beat1_q),
    .rdata_i       (bus_rdata),
    .be_o          (be_s),
    .wdata_o       (lane_wdata_s),
    .rdata_o       (load_data_s)
  );

  always_comb begin
    start_s   = ex_valid & (ex_mem_read | ex_mem_write) & ~done_q & (state_q == ST_IDLE);
    ex_bad_s  = ~type_valid(ex_rw_type) |
                (is_misaligned(ex_rw_type, ex_addr[1:0]) & (MISALIGN_SPLIT == 0));
    in_req_s  = (state_q == ST_REQ1) | (state_q == ST_REQ2);
    beat2_s   = (state_q == ST_REQ2) | (state_q == ST_RSP2);
    // cnt_q counts cycles already spent in this beat; the current one is +1.
    timeout_s = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYCLES);
  end

  // Next-state, counter and completion logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0000_0000;
    beat1_d = beat1_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (start_s && ex_bad_s) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (start_s) begin
          state_d = ST_REQ1;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ1, ST_REQ2: begin
        // An accepted request takes priority over a coincident timeout.
        if (bus_gnt) begin
          state_d = (state_q == ST_REQ1) ? ST_RSP1 : ST_RSP2;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RSP1, ST_RSP2: begin
        if (bus_rvalid && bus_err) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (bus_rvalid && (state_q == ST_RSP1) && two_beat_q) begin
          state_d = ST_REQ2;
          cnt_d   = {CW{1'b0}};
          beat1_d = bus_rdata;
        end else if (bus_rvalid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          rdata_d = is_load_q ? load_data_s : 32'h0000_0000;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // FSM, timeout counter and registered completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      beat1_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      beat1_q <= beat1_d;
    end
  end

  // Operation capture at start; held for the whole access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_load_q  <= 1'b0;
      two_beat_q <= 1'b0;
      type_q     <= 3'b000;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
    end else if (start_s) begin
      is_load_q  <= ex_mem_read;
      two_beat_q <= is_misaligned(ex_rw_type, ex_addr[1:0]);
      type_q     <= ex_rw_type;
      addr_q     <= ex_addr;
      wdata_q    <= ex_wdata;
    end else begin
      is_load_q  <= is_load_q;
      two_beat_q <= two_beat_q;
      type_q     <= type_q;
      addr_q     <= addr_q;
      wdata_q    <= wdata_q;
    end
  end

  // Bus outputs are decoded from registered state and captured operands only.
  always_comb begin
    lsu_stall = start_s | (state_q != ST_IDLE);
    lsu_done  = done_q;
    lsu_err   = err_q;
    lsu_rdata = rdata_q;
    bus_req   = in_req_s;
    bus_we    = in_req_s & ~is_load_q;
    if (in_req_s) begin
      bus_addr  = {addr_q[31:2], 2'b00} + (beat2_s ? 32'd4 : 32'd0);
      bus_be    = be_s;
      bus_wdata = is_load_q ? 32'h0000_0000 : lane_wdata_s;
    end else begin
      bus_addr  = 32'h0000_0000;
      bus_be    = 4'h0;
      bus_wdata = 32'h0000_0000;
    end
  end

endmodule
